if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the opcode decoder.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction and PC+4 into IF/ID; the ID stage slices the opcode field [31:26] from this register.
- Handles stall (hazard unit), redirect (branch/jump resolution) and bubble insertion.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_stage_ifid_reg.sv | 34 +++
 rtl/if_stage.sv | 115 +++++++++++
 tb/tb_if_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP word, fetch FSM states and
// the opcode field position used by the decoder.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetchState_e;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// A bubble overrides a load and leaves the stored PC+4 untouched.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] fetchInstr,
  input  logic [XLEN-1:0]    fetchPc4,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [XLEN-1:0]    ifidPc4,
  output logic               ifidValid
);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      ifidInstr <= NOP_INSTR;
      ifidPc4   <= '0;
      ifidValid <= 1'b0;
    end else if (bubble) begin
      ifidInstr <= NOP_INSTR;
      ifidValid <= 1'b0;
    end else if (load) begin
      ifidInstr <= fetchInstr;
      ifidPc4   <= fetchPc4;
      ifidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, boot FSM, next-PC mux and IF/ID register.
// Optional performance counters are enabled with macro IF_STAGE_PERF_CNT_EN.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [XLEN-1:0]    ifid_pc4_o,
  output logic               ifid_valid_o
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_o,
  output logic [31:0]        perf_stall_o,
  output logic [31:0]        perf_flush_o
`endif
);

  fetchState_e     state, stateNext;
  logic [XLEN-1:0] pc, pcNext, pcPlus4;
  logic            ifidLoad, ifidBubble;
  logic            doAdvance, doStall, doFlush;

  assign pcPlus4     = pc + 32'd4;
  assign imem_addr_o = pc;
  assign pc_o        = pc;

  // Redirect wins over stall, stall wins over advance; BOOT only inserts a bubble.
  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    ifidLoad   = 1'b0;
    ifidBubble = 1'b0;
    doAdvance  = 1'b0;
    doStall    = 1'b0;
    doFlush    = 1'b0;
    case (state)
      BOOT: begin
        stateNext  = RUN;
        ifidBubble = 1'b1;
      end
      RUN: begin
        if (redirect_i) begin
          pcNext     = alignPc(redirect_pc_i);
          ifidBubble = 1'b1;
          doFlush    = 1'b1;
        end else if (stall_i) begin
          doStall = 1'b1;
        end else begin
          pcNext    = pcPlus4;
          ifidLoad  = 1'b1;
          doAdvance = 1'b1;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifidReg (
    .clk       (clk_i),
    .rstN      (rst_i),
    .load      (ifidLoad),
    .bubble    (ifidBubble),
    .fetchInstr(imem_data_i),
    .fetchPc4  (pcPlus4),
    .ifidInstr (ifid_instr_o),
    .ifidPc4   (ifid_pc4_o),
    .ifidValid (ifid_valid_o)
  );

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perfFetch, perfStall, perfFlush;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perfFetch <= '0;
      perfStall <= '0;
      perfFlush <= '0;
    end else begin
      if (doAdvance) perfFetch <= perfFetch + 32'd1;
      if (doStall)   perfStall <= perfStall + 32'd1;
      if (doFlush)   perfFlush <= perfFlush + 32'd1;
    end
  end

  assign perf_fetch_o = perfFetch;
  assign perf_stall_o = perfStall;
  assign perf_flush_o = perfFlush;
`else
  logic unusedCtl;
  assign unusedCtl = doAdvance ^ doStall ^ doFlush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table replayed through a scoreboard
// queue, plus hand sequences for reset, boot and the performance counters.
module tb_if_stage;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_fetch_o, perf_stall_o, perf_flush_o;
`endif

  int   checks   = 0;
  int   failures = 0;
  vec_t sbQ[$];
  vec_t tbl[16];

  if_stage dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_valid_o (ifid_valid_o)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch_o),
    .perf_stall_o (perf_stall_o),
    .perf_flush_o (perf_flush_o)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory model: word at address A is 0x20010005 + A.
  assign imem_data_i = 32'h2001_0005 + imem_addr_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic checkState(input string nm, input vec_t e);
    chk({nm, ".pc"},    pc_o,                 e.pc);
    chk({nm, ".addr"},  imem_addr_o,          e.pc);
    chk({nm, ".instr"}, ifid_instr_o,         e.instr);
    chk({nm, ".pc4"},   ifid_pc4_o,           e.pc4);
    chk({nm, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, e.valid});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic applyStep(input string nm, input vec_t v);
    vec_t e;
    stall_i       = v.stall;
    redirect_i    = v.redirect;
    redirect_pc_i = v.rpc;
    sbQ.push_back(v);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=0 required=1", nm);
    end else begin
      e = sbQ.pop_front();
      checkState(nm, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h2001_0005, 32'h4,   1'b1};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h2001_0009, 32'h8,   1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'h2001_000D, 32'hC,   1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        32'h10,       32'h2001_0011, 32'h10,  1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        32'h10,       32'h2001_0011, 32'h10,  1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,        32'h10,       32'h2001_0011, 32'h10,  1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        32'h10,       32'h2001_0011, 32'h10,  1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h14,       32'h2001_0015, 32'h14,  1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'h43,       32'h40,       32'h0,         32'h14,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h44,       32'h2001_0045, 32'h44,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,       32'h44,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h2001_0001, 32'h0,   1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h100,      32'h100,      32'h0,         32'h0,   1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h207,      32'h204,      32'h0,         32'h0,   1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        32'h208,      32'h2001_0209, 32'h208, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 32'h0,        32'h208,      32'h2001_0209, 32'h208, 1'b1};

    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    e = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    checkState("reset", e);

    // First edge after release is the BOOT cycle: bubble, PC held.
    rst_i = 1'b1;
    applyStep("boot", e);

    for (int i = 0; i < 16; i++) applyStep($sformatf("s%0d", i), tbl[i]);

`ifdef IF_STAGE_PERF_CNT_EN
    chk("perfFetch.tbl", perf_fetch_o, 32'd8);
    chk("perfStall.tbl", perf_stall_o, 32'd4);
    chk("perfFlush.tbl", perf_flush_o, 32'd4);
`endif

    // Reset mid-run overrides a simultaneous stall and redirect.
    rst_i = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h123;
    @(posedge clk);
    #1;
    e = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    checkState("midrst", e);
`ifdef IF_STAGE_PERF_CNT_EN
    chk("perfFetch.rst", perf_fetch_o, 32'd0);
    chk("perfStall.rst", perf_stall_o, 32'd0);
    chk("perfFlush.rst", perf_flush_o, 32'd0);
`endif

    // BOOT ignores stall: the following cycle must advance.
    rst_i = 1'b1;
    applyStep("boot2", '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
    applyStep("adv1", '{1'b0, 1'b0, 32'h0, 32'h4,  32'h2001_0005, 32'h4,  1'b1});
    applyStep("adv2", '{1'b0, 1'b0, 32'h0, 32'h8,  32'h2001_0009, 32'h8,  1'b1});
    applyStep("adv3", '{1'b0, 1'b0, 32'h0, 32'hC,  32'h2001_000D, 32'hC,  1'b1});
    applyStep("adv4", '{1'b0, 1'b0, 32'h0, 32'h10, 32'h2001_0011, 32'h10, 1'b1});
    applyStep("adv5", '{1'b0, 1'b0, 32'h0, 32'h14, 32'h2001_0015, 32'h14, 1'b1});
    applyStep("stl1", '{1'b1, 1'b0, 32'h0, 32'h14, 32'h2001_0015, 32'h14, 1'b1});
    applyStep("stl2", '{1'b1, 1'b0, 32'h0, 32'h14, 32'h2001_0015, 32'h14, 1'b1});
    applyStep("rdr1", '{1'b0, 1'b1, 32'h82, 32'h80, 32'h0,        32'h14, 1'b0});
`ifdef IF_STAGE_PERF_CNT_EN
    chk("perfFetch", perf_fetch_o, 32'd5);
    chk("perfStall", perf_stall_o, 32'd2);
    chk("perfFlush", perf_flush_o, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
